// File: rtl/voxel_mem_pkg.sv
// rtl/voxel_mem_pkg.sv - shared types and sizing helpers for the voxel occupancy store
package voxel_mem_pkg;

  localparam int PKG_X_BITS    = 5;
  localparam int PKG_Y_BITS    = 5;
  localparam int PKG_Z_BITS    = 5;
  localparam int PKG_WORD_BITS = 32;
  localparam int PKG_BIT_BITS  = $clog2(PKG_WORD_BITS);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [PKG_X_BITS-1:0]   x;
    logic [PKG_Y_BITS-1:0]   y;
    logic [PKG_Z_BITS-1:0]   z;
    logic                    oob;
    logic [PKG_BIT_BITS-1:0] bit_idx;
  } stage_pay_t;

  function automatic int calc_num_words(input int gx, input int gy, input int gz, input int wb);
    return (gx * gy * gz) / wb;
  endfunction

  function automatic int calc_addr_bits(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/voxel_bit_ram.sv
// rtl/voxel_bit_ram.sv - single-port synchronous RAM, 1-cycle read, stand-in for an SRAM macro
module voxel_bit_ram #(
  parameter int WORD_BITS = 32,
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clock,
  input  logic                 i_en,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [WORD_BITS-1:0] i_wdata,
  output logic [WORD_BITS-1:0] o_rdata
);

  logic [WORD_BITS-1:0] r_mem [NUM_WORDS];
  logic [WORD_BITS-1:0] r_rdata;

  // Read data holds its last value on write cycles, matching macro behaviour.
  always_ff @(posedge clock) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/voxel_occupancy_mem.sv
// rtl/voxel_occupancy_mem.sv - voxel solid-query store with word load and bulk clear
module voxel_occupancy_mem
  import voxel_mem_pkg::*;
#(
  parameter int X_BITS    = PKG_X_BITS,
  parameter int Y_BITS    = PKG_Y_BITS,
  parameter int Z_BITS    = PKG_Z_BITS,
  parameter int GRID_X    = 32,
  parameter int GRID_Y    = 32,
  parameter int GRID_Z    = 32,
  parameter int WORD_BITS = PKG_WORD_BITS,
  localparam int NUM_WORDS = calc_num_words(GRID_X, GRID_Y, GRID_Z, WORD_BITS),
  localparam int ADDR_BITS = calc_addr_bits(NUM_WORDS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [X_BITS-1:0]    req_x,
  input  logic [Y_BITS-1:0]    req_y,
  input  logic [Z_BITS-1:0]    req_z,
  output logic                 resp_valid,
  output logic                 resp_solid,
  output logic                 resp_oob,
  output logic [X_BITS-1:0]    resp_x,
  output logic [Y_BITS-1:0]    resp_y,
  output logic [Z_BITS-1:0]    resp_z,
  input  logic                 flush,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [WORD_BITS-1:0] load_data,
  input  logic                 clear_start,
  output logic                 clear_busy,
  output logic                 clear_done
);

  localparam int IDX_BITS = X_BITS + Y_BITS + Z_BITS;
  localparam int BIT_BITS = $clog2(WORD_BITS);

  state_e                 r_state, w_state_nxt;
  logic                   r_run;
  logic [ADDR_BITS-1:0]   r_clr_cnt;
  logic                   r_clear_done;
  logic                   r_s1_valid;
  stage_pay_t             r_s1_pay;
  logic                   r_resp_valid, r_resp_solid, r_resp_oob;
  logic [X_BITS-1:0]      r_resp_x;
  logic [Y_BITS-1:0]      r_resp_y;
  logic [Z_BITS-1:0]      r_resp_z;

  logic                   w_clr_last, w_clr_we, w_load_we, w_fire, w_oob, w_rd;
  logic [IDX_BITS-1:0]    w_idx;
  logic [ADDR_BITS-1:0]   w_word;
  logic [BIT_BITS-1:0]    w_bit;
  logic                   w_ram_en, w_ram_we;
  logic [ADDR_BITS-1:0]   w_ram_addr;
  logic [WORD_BITS-1:0]   w_ram_wdata, w_rdata;

  assign w_clr_last = (r_clr_cnt == ADDR_BITS'(NUM_WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clear_start) w_state_nxt = CLEAR;
      CLEAR:   if (w_clr_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_run keeps req_ready low while reset is asserted even though state is IDLE.
  assign req_ready  = r_run && (r_state == IDLE) && !load_en && !flush;
  assign clear_busy = (r_state == CLEAR);
  assign clear_done = r_clear_done;

  assign w_fire = req_valid && req_ready;
  assign w_oob  = (32'(req_x) >= GRID_X) || (32'(req_y) >= GRID_Y) || (32'(req_z) >= GRID_Z);
  assign w_idx  = (IDX_BITS'(req_z) * IDX_BITS'(GRID_Y) + IDX_BITS'(req_y)) * IDX_BITS'(GRID_X)
                + IDX_BITS'(req_x);
  assign w_word = ADDR_BITS'(w_idx >> BIT_BITS);
  assign w_bit  = w_idx[BIT_BITS-1:0];
  assign w_rd   = w_fire && !w_oob;

  assign w_clr_we  = (r_state == CLEAR);
  assign w_load_we = (r_state == IDLE) && load_en;

  // One port: clear write beats load write beats query read.
  always_comb begin
    w_ram_en    = w_clr_we || w_load_we || w_rd;
    w_ram_we    = w_clr_we || w_load_we;
    w_ram_addr  = w_word;
    w_ram_wdata = '0;
    if (w_clr_we) begin
      w_ram_addr = r_clr_cnt;
    end else if (w_load_we) begin
      w_ram_addr  = load_addr;
      w_ram_wdata = load_data;
    end
  end

  voxel_bit_ram #(
    .WORD_BITS (WORD_BITS),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clock   (clock),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_run        <= 1'b0;
      r_clr_cnt    <= '0;
      r_clear_done <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_pay     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_solid <= 1'b0;
      r_resp_oob   <= 1'b0;
      r_resp_x     <= '0;
      r_resp_y     <= '0;
      r_resp_z     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_run        <= 1'b1;
      r_clr_cnt    <= (r_state == CLEAR) ? r_clr_cnt + ADDR_BITS'(1) : '0;
      r_clear_done <= (r_state == CLEAR) && w_clr_last;
      r_s1_valid   <= w_fire && !flush;
      if (w_fire) begin
        r_s1_pay.x       <= PKG_X_BITS'(req_x);
        r_s1_pay.y       <= PKG_Y_BITS'(req_y);
        r_s1_pay.z       <= PKG_Z_BITS'(req_z);
        r_s1_pay.oob     <= w_oob;
        r_s1_pay.bit_idx <= PKG_BIT_BITS'(w_bit);
      end
      r_resp_valid <= r_s1_valid && !flush;
      if (r_s1_valid) begin
        r_resp_solid <= w_rdata[r_s1_pay.bit_idx] && !r_s1_pay.oob;
        r_resp_oob   <= r_s1_pay.oob;
        r_resp_x     <= X_BITS'(r_s1_pay.x);
        r_resp_y     <= Y_BITS'(r_s1_pay.y);
        r_resp_z     <= Z_BITS'(r_s1_pay.z);
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_solid = r_resp_solid;
  assign resp_oob   = r_resp_oob;
  assign resp_x     = r_resp_x;
  assign resp_y     = r_resp_y;
  assign resp_z     = r_resp_z;

endmodule

// File: tb/tb_voxel_occupancy_mem.sv
// tb/tb_voxel_occupancy_mem.sv - scoreboard bench for voxel_occupancy_mem with a 20x32x32 grid
module tb_voxel_occupancy_mem;

  localparam int GX = 20;
  localparam int GY = 32;
  localparam int GZ = 32;
  localparam int NW = GX * GY * GZ / 32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_x = '0, req_y = '0, req_z = '0;
  logic        resp_valid, resp_solid, resp_oob;
  logic [4:0]  resp_x, resp_y, resp_z;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        clear_start = 1'b0;
  logic        clear_busy, clear_done;

  voxel_occupancy_mem #(.GRID_X(GX), .GRID_Y(GY), .GRID_Z(GZ)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .resp_valid(resp_valid), .resp_solid(resp_solid), .resp_oob(resp_oob),
    .resp_x(resp_x), .resp_y(resp_y), .resp_z(resp_z),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit         solid;
    bit         oob;
    logic [4:0] x, y, z;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   failures = 0;
  int   n_resp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic query(input logic [4:0] x, input logic [4:0] y, input logic [4:0] z,
                       input bit solid, input bit oob, input bit expect_resp);
    req_valid = 1'b1;
    req_x = x; req_y = y; req_z = z;
    #1;
    check("req_ready_query", req_ready, 1);
    if (expect_resp) sb.push_back('{solid, oob, x, y, z, cyc + 2});
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick(1);
    load_en = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset_n && resp_valid) begin
      n_resp++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected actual=(%0d,%0d,%0d) required=no response (cycle %0d)",
                 resp_x, resp_y, resp_z, cyc);
      end else begin
        m_e = sb.pop_front();
        check("resp_solid", resp_solid, m_e.solid);
        check("resp_oob", resp_oob, m_e.oob);
        check("resp_echo", {resp_x, resp_y, resp_z}, {m_e.x, m_e.y, m_e.z});
        check("resp_cycle", cyc, m_e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, base, nd;
    tick(2);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_solid", resp_solid, 0);
    check("rst_resp_oob", resp_oob, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_clear_done", clear_done, 0);
    reset_n = 1'b1;
    tick(2);
    check("post_rst_req_ready", req_ready, 1);

    load(0, 32'h0000_0010);
    query(4, 0, 0, 1, 0, 1);
    query(5, 0, 0, 0, 0, 1);
    load(1, 32'hA5A5_0003);
    load(639, 32'h8000_0000);
    query(13, 1, 0, 1, 0, 1);
    query(14, 1, 0, 0, 0, 1);
    query(3, 3, 0, 1, 0, 1);
    query(19, 31, 31, 1, 0, 1);
    query(18, 31, 31, 0, 0, 1);
    query(25, 3, 3, 0, 1, 1);
    query(20, 0, 0, 0, 1, 1);

    load(0, 32'h0000_000A);
    query(1, 0, 0, 1, 0, 1);
    query(2, 0, 0, 0, 0, 1);
    query(3, 0, 0, 1, 0, 1);

    load_en = 1'b1; load_addr = 0; load_data = 32'h0000_0004;
    req_valid = 1'b1; req_x = 2; req_y = 0; req_z = 0;
    #1;
    check("req_ready_during_load", req_ready, 0);
    tick(1);
    load_en = 1'b0;
    query(2, 0, 0, 1, 0, 1);
    tick(3);
    check("drain_1", sb.size(), 0);

    query(2, 0, 0, 1, 0, 1);
    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    nb = 0;
    for (int i = 1; i <= NW; i++) begin
      if (clear_busy) nb++;
      if (i == 2) clear_start = 1'b1;
      if (i == 3) clear_start = 1'b0;
      if (i == 10) begin
        req_valid = 1'b1; req_x = 4; req_y = 0; req_z = 0;
        #1;
        check("req_ready_during_clear", req_ready, 0);
      end
      if (i == 11) req_valid = 1'b0;
      if (i == 300) begin load_en = 1'b1; load_addr = 5; load_data = '1; end
      if (i == 301) load_en = 1'b0;
      tick(1);
    end
    check("clear_busy_cycles", nb, NW);
    check("clear_done_pulse", clear_done, 1);
    check("clear_busy_end", clear_busy, 0);
    check("req_ready_after_clear", req_ready, 1);
    tick(1);
    check("clear_done_one_cycle", clear_done, 0);

    query(4, 0, 0, 0, 0, 1);
    query(1, 0, 0, 0, 0, 1);
    query(3, 0, 0, 0, 0, 1);
    query(13, 1, 0, 0, 0, 1);
    query(3, 3, 0, 0, 0, 1);
    query(19, 31, 31, 0, 0, 1);
    query(0, 8, 0, 0, 0, 1);
    query(25, 3, 3, 0, 1, 1);
    tick(3);
    check("drain_2", sb.size(), 0);

    base = n_resp;
    query(1, 0, 0, 0, 0, 0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(4);
    check("flush_single", n_resp - base, 0);

    load(0, 32'h0000_0002);
    query(1, 0, 0, 1, 0, 1);
    query(3, 0, 0, 0, 0, 0);
    base = n_resp;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(4);
    check("flush_pair", n_resp - base, 1);
    check("drain_3", sb.size(), 0);

    clear_start = 1'b1;
    tick(1);
    clear_start = 1'b0;
    tick(100);
    check("busy_mid_clear", clear_busy, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_clear_busy", clear_busy, 0);
    check("rst_mid_clear_resp_valid", resp_valid, 0);
    check("rst_mid_clear_req_ready", req_ready, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("idle_after_rst_busy", clear_busy, 0);
    check("idle_after_rst_ready", req_ready, 1);
    nd = 0;
    nb = 0;
    for (int i = 0; i < NW; i++) begin
      if (clear_done) nd++;
      if (clear_busy) nb++;
      tick(1);
    end
    check("no_done_after_rst", nd, 0);
    check("no_busy_after_rst", nb, 0);
    load(0, 32'h0000_0001);
    query(0, 0, 0, 1, 0, 1);
    tick(3);
    check("drain_final", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
